vga_scaled_timing: RTL and testbench



---
 rtl/vga_scaled_timing_pkg.sv | 39 +++
 rtl/vga_scaled_timing_if.sv | 11 +
 rtl/vga_delay_line.sv | 48 ++++
 rtl/vga_scaled_timing.sv | 275 +++++++++++++++++++++++++++
 tb/tb_vga_scaled_timing.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_scaled_timing_pkg.sv
// Shared types and default 640x480 geometry for the scaled VGA timing block.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  // Default 640x480@60 timing
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Everything about a pixel that must travel alongside the frame-buffer read
  typedef struct packed {
    logic               hs;
    logic               vs;
    logic               active;
    logic               vblank;
    logic               in_vp;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    rgb_t               border;
  } vid_bundle_t;

  // Total length of a line or frame from its four segments
  function automatic int line_total(input int active, input int fp, input int sync_w, input int bp);
    return active + fp + sync_w + bp;
  endfunction

endpackage

// File: rtl/vga_scaled_timing_if.sv
// Frame-buffer read port: timing block (master) issues addresses, memory (slave) returns colour.
interface vga_scaled_timing_if #(
  parameter int AW = 16
) ();
  logic [AW-1:0] fb_addr;
  logic          fb_rd;
  logic [23:0]   vp_rgb;

  modport master (output fb_addr, output fb_rd, input vp_rgb);
  modport slave  (input fb_addr, input fb_rd, output vp_rgb);
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift pipe that advances only on pix_ce; used to align the
// sync/blank/coordinate bundle with the frame-buffer read latency.
module vga_delay_line #(
  parameter int              WIDTH     = 1,
  parameter int              DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             pixel_clk,
  input  logic             reset,
  input  logic             pix_ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Next-state of the shift stages: shift on pix_ce, otherwise hold
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (pix_ce) begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end else begin
      stage_d[0] = stage_q[0];
    end
  end

  // Stage registers; reset flushes the whole pipe to the idle bundle
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scaled_timing.sv
// VGA timing generator with integer-scaled viewport address generation.
// Outputs are aligned MEM_LAT+2 ce-cycles behind the raster counters.
// Optional feature: define VGA_BORDER_CHECKER_EN for a checkerboard border.
module vga_scaled_timing
  import vga_timing_pkg::*;
#(
  parameter int          H_ACTIVE   = DEF_H_ACTIVE,
  parameter int          H_FP       = DEF_H_FP,
  parameter int          H_SYNC     = DEF_H_SYNC,
  parameter int          H_BP       = DEF_H_BP,
  parameter int          V_ACTIVE   = DEF_V_ACTIVE,
  parameter int          V_FP       = DEF_V_FP,
  parameter int          V_SYNC     = DEF_V_SYNC,
  parameter int          V_BP       = DEF_V_BP,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int          SCALE      = 2,
  parameter int          VP_X0      = 64,
  parameter int          VP_Y0      = 0,
  parameter int          VP_W       = 256,
  parameter int          VP_H       = 240,
  parameter int          MEM_LAT    = 1,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic                pixel_clk,
  input  logic                reset,
  input  logic                pix_ce,
  vga_scaled_timing_if.master fb,
  output logic                hs,
  output logic                vs,
  output logic                active_nblank,
  output logic                sync,
  output logic [9:0]          drawX,
  output logic [9:0]          drawY,
  output logic [7:0]          Red,
  output logic [7:0]          Green,
  output logic [7:0]          Blue,
  output logic                vblank,
  output logic                frame_start
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int AW      = $clog2(VP_W * VP_H);
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int DEPTH   = MEM_LAT + 1;

  localparam logic [COORD_W-1:0] HC_LAST  = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] VC_LAST  = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] X0_C     = COORD_W'(VP_X0);
  localparam logic [COORD_W-1:0] Y0_C     = COORD_W'(VP_Y0);
  localparam logic [COORD_W:0]   VP_WS_C  = (COORD_W + 1)'(VP_W * SCALE);
  localparam logic [COORD_W:0]   VP_HS_C  = (COORD_W + 1)'(VP_H * SCALE);
  localparam logic [SW-1:0]      SX_LAST  = SW'(SCALE - 1);
  localparam logic [AW-1:0]      VP_W_A   = AW'(VP_W);

  localparam vid_bundle_t VID_RST = '{
    hs: ~SYNC_POL, vs: ~SYNC_POL, active: 1'b0, vblank: 1'b0, in_vp: 1'b0,
    x: 10'd0, y: 10'd0, border: 24'h000000
  };

  // Geometry sanity checks at elaboration
  if (VP_X0 + VP_W * SCALE > H_ACTIVE) begin : g_chk_vp_w
    $error("vga_scaled_timing: viewport exceeds active width");
  end
  if (VP_Y0 + VP_H * SCALE > V_ACTIVE) begin : g_chk_vp_h
    $error("vga_scaled_timing: viewport exceeds active height");
  end
  if (SCALE < 1) begin : g_chk_scale
    $error("vga_scaled_timing: SCALE must be at least 1");
  end
  if (MEM_LAT < 1) begin : g_chk_lat
    $error("vga_scaled_timing: MEM_LAT must be at least 1");
  end

  logic [COORD_W-1:0] hc_q, hc_d, vc_q, vc_d;
  logic [SW-1:0]      sx_q, sx_d, sy_q, sy_d;
  logic [AW-1:0]      col_q, col_d, row_base_q, row_base_d;
  logic [AW-1:0]      fb_addr_q, fb_addr_d;
  logic               fb_rd_q, fb_rd_d;
  rgb_t               rgb_cap_q, rgb_cap_d;
  logic               hs_q, hs_d, vs_q, vs_d, active_q, active_d, vblank_q, vblank_d;
  logic [COORD_W-1:0] drawx_q, drawx_d, drawy_q, drawy_d;
  rgb_t               rgb_q, rgb_d;
  logic               frame_start_q, frame_start_d;

  logic        hc_last_s, vc_last_s, in_vp_h_s, in_vp_v_s, in_vp_s;
  rgb_t        border_s;
  vid_bundle_t vid_s, vid_dl_s;

  // Decode the current raster position into sync/blank/viewport flags
  always_comb begin
    hc_last_s = (hc_q == HC_LAST);
    vc_last_s = (vc_q == VC_LAST);
    // Offset compare: positions left/above the origin wrap to large values
    in_vp_h_s = ({1'b0, hc_q - X0_C} < VP_WS_C);
    in_vp_v_s = ({1'b0, vc_q - Y0_C} < VP_HS_C);
    in_vp_s   = in_vp_h_s && in_vp_v_s;
`ifdef VGA_BORDER_CHECKER_EN
    border_s = (hc_q[2] ^ vc_q[2]) ? 24'hFFFFFF : 24'h000000;
`else
    border_s = BORDER_RGB;
`endif
    vid_s.hs     = ((hc_q >= HS_START) && (hc_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vid_s.vs     = ((vc_q >= VS_START) && (vc_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
    vid_s.active = (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
    vid_s.vblank = (vc_q >= V_ACT_C);
    vid_s.in_vp  = in_vp_s;
    vid_s.x      = hc_q;
    vid_s.y      = vc_q;
    vid_s.border = border_s;
  end

  // Raster counters plus incremental source-pixel address (col/row_base)
  always_comb begin
    hc_d       = hc_q;
    vc_d       = vc_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    col_d      = col_q;
    row_base_d = row_base_q;
    if (pix_ce) begin
      hc_d = hc_last_s ? 10'd0 : hc_q + 10'd1;
      if (hc_last_s) begin
        vc_d = vc_last_s ? 10'd0 : vc_q + 10'd1;
      end else begin
        vc_d = vc_q;
      end
      // Horizontal: one source column per SCALE screen pixels
      if (in_vp_s) begin
        if (sx_q == SX_LAST) begin
          sx_d  = '0;
          col_d = col_q + AW'(1);
        end else begin
          sx_d  = sx_q + SW'(1);
          col_d = col_q;
        end
      end else begin
        sx_d  = '0;
        col_d = '0;
      end
      // Vertical: one source row per SCALE viewport lines, cleared per frame
      if (hc_last_s && vc_last_s) begin
        sy_d       = '0;
        row_base_d = '0;
      end else if (hc_last_s && in_vp_v_s) begin
        if (sy_q == SX_LAST) begin
          sy_d       = '0;
          row_base_d = row_base_q + VP_W_A;
        end else begin
          sy_d       = sy_q + SW'(1);
          row_base_d = row_base_q;
        end
      end else begin
        sy_d       = sy_q;
        row_base_d = row_base_q;
      end
    end else begin
      hc_d = hc_q;
    end
  end

  // Frame-buffer request, returned-colour capture and aligned output stage
  always_comb begin
    fb_addr_d = fb_addr_q;
    fb_rd_d   = fb_rd_q;
    rgb_cap_d = rgb_cap_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    active_d  = active_q;
    vblank_d  = vblank_q;
    drawx_d   = drawx_q;
    drawy_d   = drawy_q;
    rgb_d     = rgb_q;
    if (pix_ce) begin
      fb_addr_d = in_vp_s ? (row_base_q + col_q) : fb_addr_q;
      fb_rd_d   = in_vp_s;
      rgb_cap_d = fb.vp_rgb;
      hs_d      = vid_dl_s.hs;
      vs_d      = vid_dl_s.vs;
      active_d  = vid_dl_s.active;
      vblank_d  = vid_dl_s.vblank;
      drawx_d   = vid_dl_s.x;
      drawy_d   = vid_dl_s.y;
      if (vid_dl_s.active && vid_dl_s.in_vp) begin
        rgb_d = rgb_cap_q;
      end else if (vid_dl_s.active) begin
        rgb_d = vid_dl_s.border;
      end else begin
        rgb_d = 24'h000000;
      end
    end else begin
      rgb_d = rgb_q;
    end
  end

  // Frame pulse on the counter wrap to (0,0); self-clears on the next clock
  always_comb begin
    frame_start_d = pix_ce && hc_last_s && vc_last_s;
  end

  // Alignment pipe for the per-pixel bundle
  vga_delay_line #(
    .WIDTH     ($bits(vid_bundle_t)),
    .DEPTH     (DEPTH),
    .RESET_VAL (VID_RST)
  ) u_delay (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .pix_ce    (pix_ce),
    .din       (vid_s),
    .dout      (vid_dl_s)
  );

  // State and output registers with synchronous reset
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      hc_q          <= 10'd0;
      vc_q          <= 10'd0;
      sx_q          <= '0;
      sy_q          <= '0;
      col_q         <= '0;
      row_base_q    <= '0;
      fb_addr_q     <= '0;
      fb_rd_q       <= 1'b0;
      rgb_cap_q     <= 24'h000000;
      hs_q          <= ~SYNC_POL;
      vs_q          <= ~SYNC_POL;
      active_q      <= 1'b0;
      vblank_q      <= 1'b0;
      drawx_q       <= 10'd0;
      drawy_q       <= 10'd0;
      rgb_q         <= 24'h000000;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      col_q         <= col_d;
      row_base_q    <= row_base_d;
      fb_addr_q     <= fb_addr_d;
      fb_rd_q       <= fb_rd_d;
      rgb_cap_q     <= rgb_cap_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      active_q      <= active_d;
      vblank_q      <= vblank_d;
      drawx_q       <= drawx_d;
      drawy_q       <= drawy_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign fb.fb_addr    = fb_addr_q;
  assign fb.fb_rd      = fb_rd_q;
  assign hs            = hs_q;
  assign vs            = vs_q;
  assign active_nblank = active_q;
  assign sync          = 1'b0;
  assign drawX         = drawx_q;
  assign drawY         = drawy_q;
  assign Red           = rgb_q.r;
  assign Green         = rgb_q.g;
  assign Blue          = rgb_q.b;
  assign vblank        = vblank_q;
  assign frame_start   = frame_start_q;

endmodule

// File: tb/tb_vga_scaled_timing.sv
// Randomised self-checking bench for vga_scaled_timing on a small geometry.
// The reference model works from the linear count of ce-cycles since reset.
module tb_vga_scaled_timing;

  localparam int HA = 24, HF = 2, HS = 3, HB = 3;
  localparam int VA = 16, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 32
  localparam int VT = VA + VF + VS + VB;   // 21
  localparam int FRAME = HT * VT;          // 672
  localparam int S = 2, X0 = 4, Y0 = 2, W = 8, H = 6;
  localparam int ML = 3;
  localparam int L = ML + 2;
  localparam int AW = $clog2(W * H);       // 6
  localparam bit SP = 1'b0;
  localparam logic [23:0] BRGB = 24'h123456;

  logic clk = 1'b0;
  logic reset, pix_ce;
  logic hs, vs, active_nblank, sync, vblank, frame_start;
  logic [9:0] drawX, drawY;
  logic [7:0] Red, Green, Blue;

  always #5 clk = ~clk;

  vga_scaled_timing_if #(.AW(AW)) fb ();

  vga_scaled_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(SP), .SCALE(S), .VP_X0(X0), .VP_Y0(Y0),
    .VP_W(W), .VP_H(H), .MEM_LAT(ML), .BORDER_RGB(BRGB)
  ) dut (
    .pixel_clk(clk), .reset(reset), .pix_ce(pix_ce), .fb(fb),
    .hs(hs), .vs(vs), .active_nblank(active_nblank), .sync(sync),
    .drawX(drawX), .drawY(drawY), .Red(Red), .Green(Green), .Blue(Blue),
    .vblank(vblank), .frame_start(frame_start)
  );

  // Frame-buffer model: static random contents, MEM_LAT-1 ce-stages after fb_addr
  logic [23:0] mem [64];
  logic [23:0] m1, m2;
  always @(posedge clk) begin
    if (pix_ce) begin
      m1 <= mem[fb.fb_addr];
      m2 <= m1;
    end
  end
  assign fb.vp_rgb = m2;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int last_addr = 0;
  bit armed = 1'b0;
  bit phase1 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d actual=%0h required=%0h", name, n, act, exp);
    end
  endtask

  function automatic bit in_vp_f(input int h, input int v);
    return (h >= X0) && (h < X0 + W * S) && (v >= Y0) && (v < Y0 + H * S);
  endfunction

  function automatic int addr_f(input int h, input int v);
    return ((v - Y0) / S) * W + (h - X0) / S;
  endfunction

  function automatic logic [23:0] border_f(input int h, input int v);
`ifdef VGA_BORDER_CHECKER_EN
    return (((h >> 2) ^ (v >> 2)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
`else
    return BRGB;
`endif
  endfunction

  // Model update on every clock edge, compare 1 time unit later
  initial begin : compare
    int q, qh, qv, q1;
    bit fs_exp, e_rd, e_act, e_vb, e_hs, e_vs;
    logic [23:0] e_rgb;
    forever begin
      @(posedge clk);
      fs_exp = 1'b0;
      if (reset) begin
        n = 0;
        last_addr = 0;
        armed = 1'b1;
      end else if (pix_ce) begin
        n++;
        q1 = (n - 1) % FRAME;
        if (in_vp_f(q1 % HT, q1 / HT)) last_addr = addr_f(q1 % HT, q1 / HT);
        fs_exp = (n % FRAME) == 0;
      end
      #1;
      if (armed) begin
        if (n >= 1) begin
          q1 = (n - 1) % FRAME;
          e_rd = in_vp_f(q1 % HT, q1 / HT);
        end else begin
          e_rd = 1'b0;
        end
        if (n >= L) begin
          q = (n - L) % FRAME;
          qh = q % HT;
          qv = q / HT;
          e_hs = ((qh >= HA + HF) && (qh < HA + HF + HS)) ? SP : !SP;
          e_vs = ((qv >= VA + VF) && (qv < VA + VF + VS)) ? SP : !SP;
          e_act = (qh < HA) && (qv < VA);
          e_vb = qv >= VA;
          if (!e_act) e_rgb = 24'h000000;
          else if (in_vp_f(qh, qv)) e_rgb = mem[addr_f(qh, qv)];
          else e_rgb = border_f(qh, qv);
        end else begin
          qh = 0;
          qv = 0;
          e_hs = !SP;
          e_vs = !SP;
          e_act = 1'b0;
          e_vb = 1'b0;
          e_rgb = 24'h000000;
        end
        chk("fb_rd", 64'(fb.fb_rd), 64'(e_rd));
        chk("fb_addr", 64'(fb.fb_addr), 64'(last_addr));
        chk("hs", 64'(hs), 64'(e_hs));
        chk("vs", 64'(vs), 64'(e_vs));
        chk("active_nblank", 64'(active_nblank), 64'(e_act));
        chk("vblank", 64'(vblank), 64'(e_vb));
        chk("drawX", 64'(drawX), 64'(qh));
        chk("drawY", 64'(drawY), 64'(qv));
        chk("rgb", 64'({Red, Green, Blue}), 64'(e_rgb));
        chk("frame_start", 64'(frame_start), 64'(fs_exp));
        chk("sync", 64'(sync), 64'd0);
        // Hand-computed anchor points during the free-running first frames
        if (phase1) begin
          case (n)
            4:    chk("lit_active_n4", 64'(active_nblank), 64'd0);
            5: begin
              chk("lit_active_n5", 64'(active_nblank), 64'd1);
`ifndef VGA_BORDER_CHECKER_EN
              chk("lit_border_n5", 64'({Red, Green, Blue}), 64'h123456);
`endif
            end
            30:   chk("lit_hs_n30", 64'(hs), 64'd1);
            31:   chk("lit_hs_n31", 64'(hs), 64'd0);
            68:   chk("lit_rd_x3", 64'(fb.fb_rd), 64'd0);
            69:   chk("lit_rd_x4", 64'(fb.fb_rd), 64'd1);
            70:   chk("lit_addr_5_2", 64'(fb.fb_addr), 64'd0);
            71:   chk("lit_addr_6_2", 64'(fb.fb_addr), 64'd1);
            85:   chk("lit_rd_x20", 64'(fb.fb_rd), 64'd0);
            101:  chk("lit_addr_4_3", 64'(fb.fb_addr), 64'd0);
            133:  chk("lit_addr_4_4", 64'(fb.fb_addr), 64'd8);
            436:  chk("lit_addr_19_13", 64'(fb.fb_addr), 64'd47);
            672:  chk("lit_fs_frame1", 64'(frame_start), 64'd1);
            1344: chk("lit_fs_frame2", 64'(frame_start), 64'd1);
            default: ;
          endcase
        end
      end
    end
  end

  // Stimulus: driven on the falling edge
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 24'($urandom);
    reset = 1'b1;
    pix_ce = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    pix_ce = 1'b1;
    phase1 = 1'b1;
    repeat (2 * FRAME + 20) @(negedge clk);
    phase1 = 1'b0;
    // Regular 1-in-4 enable
    for (int i = 0; i < 4 * FRAME + 40; i++) begin
      @(negedge clk);
      pix_ce = (i % 4) == 0;
    end
    // Single-cycle mid-frame reset
    @(negedge clk);
    reset = 1'b1;
    pix_ce = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    // Random enable with rare resets
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      pix_ce = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 999) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
